sum_stage_gray: RTL and testbench
=================================

# sum_stage_gray

Single-stage registered adder with valid/ready handshakes on both sides, a one-hot status FSM, and a Gray-coded transfer counter. It is the design-side producer for the team's formal property checkers: it generates the registered sum `y`, the one-hot state vector and the Gray counter that those checkers consume. It sits between an operand source and a result sink in the formal top, and is reusable as a generic pipeline stage.

## Interface
- `WIDTH`, default 8: operand, sum and Gray counter width (≥2).
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `clr`  in  1: synchronous clear of the stage and the counter.
- `in_valid`  in  1: operands `a`, `b` are valid.
- `in_ready`  out  1: stage can accept operands this cycle.
- `a`, `b`  in  WIDTH: operands.
- `y`  out  WIDTH: registered sum, `(a + b) mod 2^WIDTH`.
- `carry`  out  1: carry-out of the captured sum.
- `y_valid`  out  1: `y`/`carry` hold an untransferred result.
- `y_ready`  in  1: sink accepts the result.
- `state_oh`  out  3: one-hot FSM state `{STALL, VALID, IDLE}`.
- `gray_cnt`  out  WIDTH: Gray-coded count of completed output transfers.

## Operation
- Input accept: `acc = in_valid & in_ready`.
- Output transfer: `xfer = y_valid & y_ready`.
- `in_ready = !rst & (!y_valid | y_ready)`. This is combinational and gives full throughput with back-to-back transfers.
- On `acc`: `{carry, y} <= a + b`, computed at WIDTH+1 bits. `y_valid <= 1`.
- On `xfer` without `acc`: `y_valid <= 0`. `y` and `carry` keep their last value.
- `y` and `carry` change only on `acc`. While `y_valid=1 & y_ready=0` they are held stable.
- FSM (one-hot, registered):
  - IDLE (001): `y_valid=0`.
    - `acc` → VALID; else stay.
  - VALID (010): a result is presented for its first cycle, or was refreshed by `acc`.
    - `acc` → VALID.
    - `xfer` without `acc` → IDLE.
    - `!y_ready` → STALL.
  - STALL (100): the result was presented and not taken last cycle.
    - `y_ready & !in_valid` → IDLE.
    - `y_ready & in_valid` → VALID, because this is an accept.
    - else stay.
- `state_oh` always has exactly one bit set. IDLE holds iff `y_valid=0`.
- Gray counter:
  - Binary count `n` increments by 1 on each `xfer` and wraps from `2^WIDTH-1` to 0.
  - `gray_cnt = n ^ (n >> 1)`, registered.
  - Exactly zero or one bit of `gray_cnt` changes per cycle, including at the wrap.
- `clr` (synchronous) has priority over `acc` and `xfer`:
  - Effects: `y_valid<=0`, state → IDLE, `n<=0`, `y<=0`, `carry<=0`.
  - `in_ready` still follows its equation during the `clr` cycle, but no accept occurs.
  - A transfer seen by the sink in that cycle is discarded and is not counted.

## Timing
- Reset values (asynchronous on `rst` assertion):
  - `y=0`, `carry=0`, `y_valid=0`, `state_oh=001`, `gray_cnt=0`.
  - `in_ready=0` while `rst` is high.
- First accept possible in the first rising edge after `rst` deasserts.
- Latency: operands accepted at edge k produce `y_valid=1` with `y=a+b` after edge k, visible in cycle k+1.
- Throughput: one result per cycle when `y_ready` is held high.
- Simultaneous `xfer` and `acc` in one cycle:
  - The old result is transferred and counted.
  - The new result is loaded.
  - `y_valid` stays 1 and the state is VALID.
- Reset mid-operation:
  - Any pending result is lost and not counted.
  - All outputs return to reset values immediately, without waiting for a clock edge.
- Overflow: `a+b ≥ 2^WIDTH` sets `carry=1`. `y` is the low WIDTH bits.

## Test plan
- Reset and basic sum:
  - Stimulus: WIDTH=8; `rst` pulse, then `a=8'h12`, `b=8'h34`, `in_valid=1`, `y_ready=1` for one cycle.
  - Response: next cycle `y=8'h46`, `carry=0`, `y_valid=1`, `state_oh=010`.
  - Following cycle: `y_valid=0`, `state_oh=001`, `gray_cnt=8'h01`.
- Overflow:
  - Stimulus: `a=8'hF0`, `b=8'h20`.
  - Response: `y=8'h10`, `carry=1`.
- Backpressure:
  - Stimulus: accept `a=1`, `b=2`; `y_ready=0` for 3 cycles while `in_valid=1` with `a=5`, `b=5`.
  - Response: `in_ready=0`, `y=3` held, `state_oh=100`.
  - After `y_ready=1`: `y=3` transfers, `10` loads next cycle, `gray_cnt` advances by one.
- Streaming and Gray wrap:
  - Stimulus: 256 back-to-back accepts with `y_ready=1`.
  - Response: one result per cycle, each sum correct.
  - `gray_cnt` changes by exactly one bit per transfer and returns to `8'h00` after the 256th.
- Clear with pending result:
  - Stimulus: `clr=1` while `y_valid=1` and `gray_cnt=8'h03`.
  - Response: next cycle `y_valid=0`, `y=0`, `state_oh=001`, `gray_cnt=0`; no count increment.
- Async reset mid-stall:
  - Stimulus: assert `rst` between clock edges during STALL.
  - Response: all outputs at reset values before the next edge, including `in_ready=0`.

Source files
------------

// File: rtl/sum_stage_gray_if.sv
// ============================================================================
// Module   : sum_stage_gray_if
// Brief    : Operand/result handshake bundle for the sum_stage_gray adder stage.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface sum_stage_gray_if #(
  parameter int WIDTH = 8
);
  logic             clr;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] y;
  logic             carry;
  logic             y_valid;
  logic             y_ready;
  logic [2:0]       state_oh;
  logic [WIDTH-1:0] gray_cnt;

  // master: operand source / result sink side; slave: the adder stage
  modport master (
    output clr, in_valid, a, b, y_ready,
    input  in_ready, y, carry, y_valid, state_oh, gray_cnt
  );

  modport slave (
    input  clr, in_valid, a, b, y_ready,
    output in_ready, y, carry, y_valid, state_oh, gray_cnt
  );
endinterface

`default_nettype wire

// File: rtl/sum_stage_gray.sv
// ============================================================================
// Module   : sum_stage_gray
// Brief    : Registered adder stage with valid/ready, one-hot FSM, Gray counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sum_stage_gray #(
  parameter int WIDTH = 8
) (
  input  wire logic          clk,
  input  wire logic          rst,
  sum_stage_gray_if.slave    bus
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'b001,
    ST_VALID = 3'b010,
    ST_STALL = 3'b100
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_y;
  logic             r_carry;
  logic             r_y_valid;
  logic [WIDTH-1:0] r_bin;
  logic [WIDTH-1:0] r_gray;

  logic             w_in_ready;
  logic             w_acc;
  logic             w_xfer;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_bin_next;

  // in_ready is forced low during reset so nothing is accepted mid-reset
  assign w_in_ready = !rst && (!r_y_valid || bus.y_ready);
  assign w_acc      = bus.in_valid && w_in_ready;
  assign w_xfer     = r_y_valid && bus.y_ready;
  assign w_sum      = {1'b0, bus.a} + {1'b0, bus.b};
  assign w_bin_next = r_bin + WIDTH'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_y       <= '0;
      r_carry   <= 1'b0;
      r_y_valid <= 1'b0;
      r_bin     <= '0;
      r_gray    <= '0;
    end else if (bus.clr) begin
      r_state   <= ST_IDLE;
      r_y       <= '0;
      r_carry   <= 1'b0;
      r_y_valid <= 1'b0;
      r_bin     <= '0;
      r_gray    <= '0;
    end else begin
      if (w_acc) begin
        {r_carry, r_y} <= w_sum;
        r_y_valid      <= 1'b1;
        r_state        <= ST_VALID;
      end else if (w_xfer) begin
        r_y_valid      <= 1'b0;
        r_state        <= ST_IDLE;
      end else if (r_y_valid) begin
        r_state        <= ST_STALL;
      end else begin
        r_state        <= ST_IDLE;
      end

      // Gray code is registered from the next binary value so it stays glitch-free
      if (w_xfer) begin
        r_bin  <= w_bin_next;
        r_gray <= w_bin_next ^ (w_bin_next >> 1);
      end
    end
  end

  assign bus.in_ready = w_in_ready;
  assign bus.y        = r_y;
  assign bus.carry    = r_carry;
  assign bus.y_valid  = r_y_valid;
  assign bus.state_oh = r_state;
  assign bus.gray_cnt = r_gray;

endmodule

`default_nettype wire

// File: tb/tb_sum_stage_gray.sv
// ============================================================================
// Module   : tb_sum_stage_gray
// Brief    : Directed vector bench for sum_stage_gray.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sum_stage_gray;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  sum_stage_gray_if #(.WIDTH(8)) bus ();

  sum_stage_gray #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       iv;
    logic       yr;
    logic       e_rdy;
    logic [7:0] e_y;
    logic       e_c;
    logic       e_v;
    logic [2:0] e_st;
    logic [7:0] e_g;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic iv, input logic yr);
    bus.a        = a;
    bus.b        = b;
    bus.in_valid = iv;
    bus.y_ready  = yr;
  endtask

  task automatic chk_out(input string tag, input logic [7:0] y, input logic c, input logic v,
                         input logic [2:0] st, input logic [7:0] g);
    chk({tag, ".y"},        32'(bus.y),        32'(y));
    chk({tag, ".carry"},    32'(bus.carry),    32'(c));
    chk({tag, ".y_valid"},  32'(bus.y_valid),  32'(v));
    chk({tag, ".state_oh"}, 32'(bus.state_oh), 32'(st));
    chk({tag, ".gray_cnt"}, 32'(bus.gray_cnt), 32'(g));
  endtask

  initial begin
    logic [7:0] prev_g;
    logic [7:0] ea;
    logic [7:0] eb;
    logic [8:0] es;
    logic [7:0] diff;
    int         n;

    total = 0;
    bad   = 0;

    //                a      b      iv    yr    rdy   y      c     v     st      gray
    vecs[0] = '{8'h12, 8'h34, 1'b1, 1'b1, 1'b1, 8'h46, 1'b0, 1'b1, 3'b010, 8'h00};
    vecs[1] = '{8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 8'h46, 1'b0, 1'b0, 3'b001, 8'h01};
    vecs[2] = '{8'hF0, 8'h20, 1'b1, 1'b1, 1'b1, 8'h10, 1'b1, 1'b1, 3'b010, 8'h01};
    vecs[3] = '{8'hFF, 8'h01, 1'b1, 1'b1, 1'b1, 8'h00, 1'b1, 1'b1, 3'b010, 8'h03};
    vecs[4] = '{8'h80, 8'h7F, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 3'b100, 8'h03};
    vecs[5] = '{8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 3'b001, 8'h02};
    vecs[6] = '{8'h80, 8'h7F, 1'b1, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b1, 3'b010, 8'h02};
    vecs[7] = '{8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0, 3'b001, 8'h06};

    rst     = 1'b1;
    bus.clr = 1'b0;
    drive(8'h00, 8'h00, 1'b0, 1'b0);
    step();
    step();
    chk("reset.in_ready", 32'(bus.in_ready), 32'd0);
    chk_out("reset", 8'h00, 1'b0, 1'b0, 3'b001, 8'h00);
    rst = 1'b0;

    // Table-driven basic sums, overflow, concurrent xfer/acc and stall
    for (int i = 0; i < 8; i++) begin
      drive(vecs[i].a, vecs[i].b, vecs[i].iv, vecs[i].yr);
      #1;
      chk($sformatf("vec%0d.in_ready", i), 32'(bus.in_ready), 32'(vecs[i].e_rdy));
      step();
      chk_out($sformatf("vec%0d", i), vecs[i].e_y, vecs[i].e_c, vecs[i].e_v, vecs[i].e_st, vecs[i].e_g);
    end

    // Backpressure: 1+2 held while 5+5 waits, n goes 4 -> 5 -> 6
    drive(8'd1, 8'd2, 1'b1, 1'b0);
    step();
    chk_out("bp.load", 8'd3, 1'b0, 1'b1, 3'b010, 8'h06);
    for (int k = 0; k < 3; k++) begin
      drive(8'd5, 8'd5, 1'b1, 1'b0);
      #1;
      chk($sformatf("bp%0d.in_ready", k), 32'(bus.in_ready), 32'd0);
      step();
      chk_out($sformatf("bp%0d", k), 8'd3, 1'b0, 1'b1, 3'b100, 8'h06);
    end
    drive(8'd5, 8'd5, 1'b1, 1'b1);
    step();
    chk_out("bp.release", 8'd10, 1'b0, 1'b1, 3'b010, 8'h07);
    drive(8'd0, 8'd0, 1'b0, 1'b1);
    step();
    chk_out("bp.drain", 8'd10, 1'b0, 1'b0, 3'b001, 8'h05);

    // Clear to zero, then stream 256 accepts so the counter wraps back to 0
    bus.clr = 1'b1;
    step();
    bus.clr = 1'b0;
    chk_out("clr0", 8'h00, 1'b0, 1'b0, 3'b001, 8'h00);
    prev_g = 8'h00;
    for (int i = 0; i < 256; i++) begin
      ea = 8'(i);
      eb = 8'((i * 7 + 3) & 255);
      drive(ea, eb, 1'b1, 1'b1);
      step();
      es = {1'b0, ea} + {1'b0, eb};
      n  = i;
      chk($sformatf("stream%0d.y", i),     32'(bus.y),       32'(es[7:0]));
      chk($sformatf("stream%0d.carry", i), 32'(bus.carry),   32'(es[8]));
      chk($sformatf("stream%0d.valid", i), 32'(bus.y_valid), 32'd1);
      chk($sformatf("stream%0d.gray", i),  32'(bus.gray_cnt), 32'((n ^ (n >> 1)) & 255));
      diff = bus.gray_cnt ^ prev_g;
      chk($sformatf("stream%0d.onebit", i), 32'($countones(diff) <= 1), 32'd1);
      prev_g = bus.gray_cnt;
    end
    drive(8'h00, 8'h00, 1'b0, 1'b1);
    step();
    diff = bus.gray_cnt ^ prev_g;
    chk("wrap.onebit", 32'($countones(diff) == 1), 32'd1);
    chk_out("wrap", es[7:0], es[8], 1'b0, 3'b001, 8'h00);

    // Clear with a pending result at gray_cnt=03 (n=2)
    drive(8'd1, 8'd1, 1'b1, 1'b1);
    step();
    step();
    step();
    chk_out("preclr", 8'd2, 1'b0, 1'b1, 3'b010, 8'h03);
    bus.clr = 1'b1;
    #1;
    chk("clr.in_ready", 32'(bus.in_ready), 32'd1);
    step();
    bus.clr = 1'b0;
    drive(8'd0, 8'd0, 1'b0, 1'b1);
    chk_out("clr", 8'h00, 1'b0, 1'b0, 3'b001, 8'h00);
    step();
    chk("clr.nocount", 32'(bus.gray_cnt), 32'h00);

    // Async reset while stalled
    drive(8'h33, 8'h44, 1'b1, 1'b0);
    step();
    drive(8'h33, 8'h44, 1'b0, 1'b0);
    step();
    chk_out("prerst", 8'h77, 1'b0, 1'b1, 3'b100, 8'h00);
    #2;
    rst = 1'b1;
    #1;
    chk("arst.in_ready", 32'(bus.in_ready), 32'd0);
    chk_out("arst", 8'h00, 1'b0, 1'b0, 3'b001, 8'h00);
    #2;
    rst = 1'b0;
    drive(8'h0A, 8'h0B, 1'b1, 1'b1);
    step();
    chk_out("postrst", 8'h15, 1'b0, 1'b1, 3'b010, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
